// File: rtl/clock_disp_pkg.sv
// Shared clock display types: scan FSM state, segment constants, font.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package clock_disp_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry 15 first; values 10..15 render as a dash.
  localparam logic [15:0][6:0] SEG_FONT = {
    SEG_DASH, SEG_DASH, SEG_DASH,
    SEG_DASH, SEG_DASH, SEG_DASH,
    7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010,
    7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100,
    7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational 4-bit value to active-low 7-segment pattern.
// Non-BCD values show a dash.
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_FONT[val_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with per-frame snapshot,
// leading-zero blanking and a one-cycle ghosting gap per digit.
module seg7_scan_driver
  import clock_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4,
  parameter bit LZB        = 1'b1
) (
  input  logic                    clk,
  input  logic                    clr_,
  input  logic                    enb,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   an_,
  output logic [6:0]              seg_,
  output logic                    dp_,
  output logic                    frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  state_e                  state_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_val;
  logic [6:0]              font_seg;
  logic                    slot_end;

  assign slot_end = (cnt_q == CNT_LAST);
  assign cnt_d = slot_end ? '0 : cnt_q + 1'b1;
  assign idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      state_q       <= GAP;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      frame_start   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_start <= 1'b0;
      if (slot_end) begin
        idx_q   <= idx_d;
        state_q <= GAP;
      end else if (state_q == GAP) begin
        state_q <= SHOW;
        // Frame boundary: freeze all digits so a carry can't tear.
        if (idx_q == '0) begin
          snap_digits_q <= digits;
          snap_dp_q     <= dp;
          frame_start   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic nz;
    nz    = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      nz       = nz | (snap_digits_q[4*i +: 4] != 4'd0);
      blank[i] = LZB && !nz;
    end
  end

  assign cur_val = snap_digits_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_font (
    .val_i (cur_val),
    .seg_o (font_seg)
  );

  always_comb begin
    an_  = '1;
    seg_ = SEG_BLANK;
    dp_  = 1'b1;
    if (state_q == SHOW && enb) begin
      an_[idx_q] = 1'b0;
      seg_       = blank[idx_q] ? SEG_BLANK : font_seg;
      dp_        = ~snap_dp_q[idx_q];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, SCAN_DIV=4).
// Second instance with leading-zero blanking disabled.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] S9  = 7'b0010000;
  localparam logic [6:0] SD  = 7'b0111111;
  localparam logic [6:0] SB  = 7'b1111111;

  typedef struct {
    logic [15:0]      dig;
    logic [3:0]       dpv;
    logic             en;
    logic [3:0][6:0]  seg;
    logic [3:0]       dpo;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr_ = 1'b0;
  logic        enb = 1'b1;
  logic [15:0] digits = 16'h0059;
  logic [3:0]  dp = 4'b0000;
  logic [3:0]  an_, an2_;
  logic [6:0]  seg_, seg2_;
  logic        dp_, dp2_, fs, fs2;

  int pass_cnt = 0;
  int total = 0;
  vec_t vec [6];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .LZB(1'b1)) dut (
    .clk(clk), .clr_(clr_), .enb(enb), .digits(digits), .dp(dp),
    .an_(an_), .seg_(seg_), .dp_(dp_), .frame_start(fs)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .LZB(1'b0)) dut2 (
    .clk(clk), .clr_(clr_), .enb(enb), .digits(digits), .dp(dp),
    .an_(an2_), .seg_(seg2_), .dp_(dp2_), .frame_start(fs2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    tick();
    while (fs !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("frame_start_seen", {31'd0, fs}, 32'd1);
  endtask

  initial begin
    vec[0] = '{16'h0059, 4'b0000, 1'b1, {SB, SB, S5, S9}, 4'b1111};
    vec[1] = '{16'h0000, 4'b0000, 1'b1, {SB, SB, SB, S0}, 4'b1111};
    vec[2] = '{16'h000C, 4'b0001, 1'b1, {SB, SB, SB, SD}, 4'b1110};
    vec[3] = '{16'h1234, 4'b0100, 1'b1, {S1, S2, S3, S4}, 4'b1011};
    vec[4] = '{16'h0807, 4'b0000, 1'b1, {SB, S8, S0, S7}, 4'b1111};
    vec[5] = '{16'h1234, 4'b1111, 1'b0, {SB, SB, SB, SB}, 4'b1111};

    // Reset state
    #2;
    chk("rst_an", {28'd0, an_}, 32'hF);
    chk("rst_seg", {25'd0, seg_}, {25'd0, SB});
    chk("rst_dp", {31'd0, dp_}, 32'd1);
    chk("rst_fs", {31'd0, fs}, 32'd0);

    // First frame after release
    @(negedge clk);
    clr_ = 1'b1;
    #1;
    chk("first_gap_an", {28'd0, an_}, 32'hF);
    tick();
    chk("first_d0_an", {28'd0, an_}, 32'hE);
    chk("first_d0_seg", {25'd0, seg_}, {25'd0, S9});
    chk("first_fs", {31'd0, fs}, 32'd1);
    tick();
    chk("first_fs_drop", {31'd0, fs}, 32'd0);
    tickn(2);
    chk("first_gap1_an", {28'd0, an_}, 32'hF);
    tick();
    chk("first_d1_an", {28'd0, an_}, 32'hD);
    chk("first_d1_seg", {25'd0, seg_}, {25'd0, S5});

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      digits = vec[v].dig;
      dp     = vec[v].dpv;
      enb    = vec[v].en;
      wait_fs();
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("v%0d_d%0d_an", v, d), {28'd0, an_},
            {28'd0, vec[v].en ? ~(4'b0001 << d) : 4'hF});
        chk($sformatf("v%0d_d%0d_seg", v, d), {25'd0, seg_},
            {25'd0, vec[v].seg[d]});
        chk($sformatf("v%0d_d%0d_dp", v, d), {31'd0, dp_},
            {31'd0, vec[v].dpo[d]});
        if (d < 3) begin
          tickn(3);
          chk($sformatf("v%0d_gap%0d", v, d + 1), {28'd0, an_}, 32'hF);
          tick();
        end
      end
    end

    // Period with enb=0, then immediate restore
    wait_fs();
    for (int c = 1; c < 16; c++) begin
      tick();
      if (an_ !== 4'hF || seg_ !== SB || fs !== 1'b0)
        chk($sformatf("dis_cyc%0d", c), {21'd0, an_, seg_}, {21'd0, 4'hF, SB});
    end
    tick();
    chk("dis_fs_period", {31'd0, fs}, 32'd1);
    chk("dis_an", {28'd0, an_}, 32'hF);
    enb = 1'b1;
    #1;
    chk("enb_restore_an", {28'd0, an_}, 32'hE);
    chk("enb_restore_seg", {25'd0, seg_}, {25'd0, S4});

    // LZB disabled instance shows leading zero
    digits = 16'h0000;
    dp = 4'b0000;
    wait_fs();
    tickn(12);
    chk("nolzb_d3_an", {28'd0, an2_}, 32'h7);
    chk("nolzb_d3_seg", {25'd0, seg2_}, {25'd0, S0});
    chk("lzb_d3_seg", {25'd0, seg_}, {25'd0, SB});

    // Tear-free snapshot
    digits = 16'h0059;
    wait_fs();
    wait_fs();
    tickn(8);
    chk("tear_d2_an", {28'd0, an_}, 32'hB);
    digits = 16'h0100;
    tickn(4);
    chk("tear_d3_an", {28'd0, an_}, 32'h7);
    chk("tear_d3_seg", {25'd0, seg_}, {25'd0, SB});
    wait_fs();
    chk("tear_n_d0", {25'd0, seg_}, {25'd0, S0});
    tickn(4);
    chk("tear_n_d1", {25'd0, seg_}, {25'd0, S0});
    tickn(4);
    chk("tear_n_d2", {25'd0, seg_}, {25'd0, S1});
    tickn(4);
    chk("tear_n_d3", {25'd0, seg_}, {25'd0, SB});

    // Mid-operation reset in digit-2 slot
    wait_fs();
    tickn(9);
    chk("mr_pre_an", {28'd0, an_}, 32'hB);
    clr_ = 1'b0;
    #1;
    chk("mr_an", {28'd0, an_}, 32'hF);
    chk("mr_seg", {25'd0, seg_}, {25'd0, SB});
    chk("mr_fs", {31'd0, fs}, 32'd0);
    digits = 16'h0007;
    @(negedge clk);
    clr_ = 1'b1;
    #1;
    chk("mr_gap_an", {28'd0, an_}, 32'hF);
    tick();
    chk("mr_d0_an", {28'd0, an_}, 32'hE);
    chk("mr_d0_seg", {25'd0, seg_}, {25'd0, S7});
    chk("mr_fs_after", {31'd0, fs}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
